// File: rtl/ysyx_23060180_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060180_pkg
// Shared types and constants for the core's memory arbiter and store path.
//   - arb_state_e : arbiter FSM states (IDLE/ISSUE/WAIT/RESP)
//   - REQ_IFU / REQ_LSU : requester ids, also used as grant vector bit indices
//   - WMASK_* : store byte-enable codes produced by the core's store path
//   - LAT_CNT_W : width of the read-latency counter (covers 1..7)
// ----------------------------------------------------------------------------
package ysyx_23060180_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam logic [3:0] WMASK_BYTE = 4'd1;
  localparam logic [3:0] WMASK_HALF = 4'd2;
  localparam logic [3:0] WMASK_WORD = 4'd4;

  localparam int unsigned LAT_CNT_W = 3;

  // Round-robin partner of a requester id.
  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/ysyx_23060180_rr_arb2.sv
// ----------------------------------------------------------------------------
// ysyx_23060180_rr_arb2
// Combinational two-way round-robin picker.
//   valid_i[1:0]  : request vector, bit index = requester id
//   last_grant_i  : id of the requester granted most recently
//   grant_o[1:0]  : one-hot grant (all zero when nobody requests)
// On a tie the requester that did not win last time is chosen.
// ----------------------------------------------------------------------------
module ysyx_23060180_rr_arb2
  import ysyx_23060180_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // Pick the sole requester, or the non-last one on contention.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11: begin
        if (other_req(last_grant_i) == REQ_LSU) begin
          grant_o = 2'b10;
        end else begin
          grant_o = 2'b01;
        end
      end
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060180_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060180_mem_arbiter
// Shares the core's single memory port between instruction fetch (IFU, read
// only) and load/store (LSU). One transaction in flight; round-robin on
// contention; fixed read latency RD_LATENCY (1..7); writes finish at issue.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   ifu_req_valid/_ready     : IFU request handshake (ready only in IDLE)
//   ifu_addr                 : fetch address
//   ifu_resp_valid/ifu_rdata : one-cycle response pulse / held fetch word
//   lsu_req_valid/_ready     : LSU request handshake (ready only in IDLE)
//   lsu_wr/addr/wdata/wmask  : store flag, address, data, byte-enable code
//   lsu_resp_valid/lsu_rdata : one-cycle response pulse / held load word
//   mem_rd/mem_wr            : memory strobes, only during ISSUE
//   mem_addr/wdata/wmask     : memory request fields, zero outside ISSUE
//   mem_rdata                : memory read data
//   busy                     : high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module ysyx_23060180_mem_arbiter
  import ysyx_23060180_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wr,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e           state_q, state_d;
  logic                 gnt_id_q, gnt_id_d;
  logic                 last_grant_q, last_grant_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [3:0]           wmask_q, wmask_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0]    lsu_rdata_q, lsu_rdata_d;
  logic [1:0]           grant_s;

  ysyx_23060180_rr_arb2 u_rr_arb2 (
    .valid_i      ({lsu_req_valid, ifu_req_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_s)
  );

  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;
  assign busy      = (state_q != ST_IDLE);

  // Next-state, latch updates and decoded outputs.
  always_comb begin
    state_d        = state_q;
    gnt_id_d       = gnt_id_q;
    last_grant_d   = last_grant_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    cnt_d          = cnt_q;
    ifu_rdata_d    = ifu_rdata_q;
    lsu_rdata_d    = lsu_rdata_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = 4'd0;

    case (state_q)
      ST_IDLE: begin
        // Ready is suppressed while rst is high so nothing looks accepted.
        if (!rst) begin
          ifu_req_ready = grant_s[REQ_IFU];
          lsu_req_ready = grant_s[REQ_LSU];
        end else begin
          ifu_req_ready = 1'b0;
          lsu_req_ready = 1'b0;
        end
        if (grant_s[REQ_LSU]) begin
          gnt_id_d     = REQ_LSU;
          last_grant_d = REQ_LSU;
          wr_d         = lsu_wr;
          addr_d       = lsu_addr;
          wdata_d      = lsu_wdata;
          wmask_d      = lsu_wmask;
          state_d      = ST_ISSUE;
        end else if (grant_s[REQ_IFU]) begin
          gnt_id_d     = REQ_IFU;
          last_grant_d = REQ_IFU;
          wr_d         = 1'b0;
          addr_d       = ifu_addr;
          wdata_d      = '0;
          wmask_d      = 4'd0;
          state_d      = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        mem_rd    = ~wr_q;
        mem_wr    = wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = wmask_q;
        if (wr_q) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = LAT_CNT_W'(RD_LATENCY);
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Counter holds RD_LATENCY in the first WAIT cycle, so a value of 1
        // marks issue cycle + RD_LATENCY, when memory data is valid.
        if (cnt_q <= 3'd1) begin
          if (gnt_id_q == REQ_LSU) begin
            lsu_rdata_d = mem_rdata;
          end else begin
            ifu_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_RESP: begin
        ifu_resp_valid = (gnt_id_q == REQ_IFU);
        lsu_resp_valid = (gnt_id_q == REQ_LSU);
        state_d        = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_id_q     <= REQ_IFU;
      last_grant_q <= REQ_LSU;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= 4'd0;
      cnt_q        <= 3'd0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      cnt_q        <= cnt_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
// ----------------------------------------------------------------------------
// Directed bench for ysyx_23060180_mem_arbiter. Two instances share all
// inputs: u_dut uses RD_LATENCY=1, u_dut3 uses RD_LATENCY=3.
// ----------------------------------------------------------------------------
module tb_ysyx_23060180_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_addr;
  logic        lsu_req_valid;
  logic        lsu_wr;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic [31:0] mem_rdata;

  logic        ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic        mem_rd, mem_wr, busy;
  logic [3:0]  mem_wmask;

  logic        ifu_req_ready_l3, ifu_resp_valid_l3, lsu_req_ready_l3, lsu_resp_valid_l3;
  logic [31:0] ifu_rdata_l3, lsu_rdata_l3, mem_addr_l3, mem_wdata_l3;
  logic        mem_rd_l3, mem_wr_l3, busy_l3;
  logic [3:0]  mem_wmask_l3;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ysyx_23060180_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wr(lsu_wr),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .busy(busy)
  );

  ysyx_23060180_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_l3), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid_l3), .ifu_rdata(ifu_rdata_l3),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_l3), .lsu_wr(lsu_wr),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid_l3), .lsu_rdata(lsu_rdata_l3),
    .mem_rd(mem_rd_l3), .mem_wr(mem_wr_l3), .mem_addr(mem_addr_l3), .mem_wdata(mem_wdata_l3),
    .mem_wmask(mem_wmask_l3), .mem_rdata(mem_rdata), .busy(busy_l3)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_wr = 1'b0; lsu_addr = 32'h0;
    lsu_wdata = 32'h0; lsu_wmask = 4'd0; mem_rdata = 32'h0;
  endtask

  task automatic reset_dut;
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    tick(); tick();
    #1;
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got=%b exp=00", {ifu_req_ready, lsu_req_ready}); end
    checks++; if ({busy, mem_rd, mem_wr, ifu_resp_valid, lsu_resp_valid} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, mem_rd, mem_wr, ifu_resp_valid, lsu_resp_valid}); end
    checks++; if ({mem_addr, mem_wdata, mem_wmask} !== 68'h0) begin fails++; $display("FAIL reset_mem got=%h exp=0", {mem_addr, mem_wdata, mem_wmask}); end
    checks++; if ({ifu_rdata, lsu_rdata} !== 64'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", {ifu_rdata, lsu_rdata}); end
    checks++; if (busy_l3 !== 1'b0) begin fails++; $display("FAIL reset_busy_l3 got=%b exp=0", busy_l3); end
    rst = 1'b0;
    #1;
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin fails++; $display("FAIL first_tie got=%b exp=10", {ifu_req_ready, lsu_req_ready}); end
    clear_inputs();
  endtask

  task automatic test_ifu_read;
    reset_dut();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_rdata = 32'hFFFF_0000;
    #1;
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin fails++; $display("FAIL ifu_ready got=%b exp=10", {ifu_req_ready, lsu_req_ready}); end
    tick();  // A+1
    ifu_req_valid = 1'b0;
    #1;
    checks++; if ({mem_rd, mem_wr} !== 2'b10) begin fails++; $display("FAIL ifu_issue_strobe got=%b exp=10", {mem_rd, mem_wr}); end
    checks++; if (mem_addr !== 32'h8000_0000) begin fails++; $display("FAIL ifu_issue_addr got=%h exp=80000000", mem_addr); end
    tick();  // A+2: data valid
    mem_rdata = 32'h0010_0093;
    #1;
    checks++; if ({mem_rd, ifu_resp_valid, busy} !== 3'b001) begin fails++; $display("FAIL ifu_wait got=%b exp=001", {mem_rd, ifu_resp_valid, busy}); end
    tick();  // A+3
    mem_rdata = 32'hFFFF_0003;
    #1;
    checks++; if (ifu_resp_valid !== 1'b1) begin fails++; $display("FAIL ifu_resp_valid got=%b exp=1", ifu_resp_valid); end
    checks++; if (ifu_rdata !== 32'h0010_0093) begin fails++; $display("FAIL ifu_rdata got=%h exp=00100093", ifu_rdata); end
    checks++; if ({lsu_resp_valid, lsu_rdata} !== 33'h0) begin fails++; $display("FAIL ifu_lsu_quiet got=%h exp=0", {lsu_resp_valid, lsu_rdata}); end
    tick();  // A+4
    #1;
    checks++; if ({ifu_resp_valid, busy} !== 2'b00) begin fails++; $display("FAIL ifu_done got=%b exp=00", {ifu_resp_valid, busy}); end
    checks++; if (ifu_rdata !== 32'h0010_0093) begin fails++; $display("FAIL ifu_rdata_hold got=%h exp=00100093", ifu_rdata); end
  endtask

  task automatic test_lsu_store;
    reset_dut();
    lsu_req_valid = 1'b1; lsu_wr = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'd4;
    #1;
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin fails++; $display("FAIL st_ready got=%b exp=01", {ifu_req_ready, lsu_req_ready}); end
    tick();  // A+1
    lsu_req_valid = 1'b0;
    #1;
    checks++; if ({mem_rd, mem_wr} !== 2'b01) begin fails++; $display("FAIL st_strobe got=%b exp=01", {mem_rd, mem_wr}); end
    checks++; if ({mem_addr, mem_wdata, mem_wmask} !== {32'h8000_1000, 32'hDEAD_BEEF, 4'd4}) begin fails++; $display("FAIL st_fields got=%h exp=%h", {mem_addr, mem_wdata, mem_wmask}, {32'h8000_1000, 32'hDEAD_BEEF, 4'd4}); end
    tick();  // A+2
    #1;
    checks++; if ({mem_wr, lsu_resp_valid, ifu_resp_valid} !== 3'b010) begin fails++; $display("FAIL st_resp got=%b exp=010", {mem_wr, lsu_resp_valid, ifu_resp_valid}); end
    checks++; if ({mem_addr, mem_wdata, mem_wmask} !== 68'h0) begin fails++; $display("FAIL st_mem_idle got=%h exp=0", {mem_addr, mem_wdata, mem_wmask}); end
    tick();  // A+3
    #1;
    checks++; if ({busy, lsu_resp_valid} !== 2'b00) begin fails++; $display("FAIL st_done got=%b exp=00", {busy, lsu_resp_valid}); end
    checks++; if (lsu_rdata !== 32'h0) begin fails++; $display("FAIL st_rdata_untouched got=%h exp=0", lsu_rdata); end
  endtask

  task automatic test_store_zero_mask;
    int wr_cnt, resp_cnt;
    wr_cnt = 0; resp_cnt = 0;
    reset_dut();
    lsu_req_valid = 1'b1; lsu_wr = 1'b1; lsu_addr = 32'h8000_2000;
    lsu_wdata = 32'h0000_0055; lsu_wmask = 4'd0;
    tick();
    lsu_req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (mem_wr) wr_cnt++;
      if (lsu_resp_valid) resp_cnt++;
      tick();
    end
    checks++; if (wr_cnt !== 1) begin fails++; $display("FAIL zmask_wr_pulses got=%0d exp=1", wr_cnt); end
    checks++; if (resp_cnt !== 1) begin fails++; $display("FAIL zmask_resp got=%0d exp=1", resp_cnt); end
  endtask

  task automatic test_round_robin;
    int ng, ifu_cnt, lsu_cnt, both_cnt;
    logic [3:0] seq;
    ng = 0; ifu_cnt = 0; lsu_cnt = 0; both_cnt = 0; seq = 4'b0000;
    reset_dut();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_wr = 1'b0; lsu_addr = 32'h8000_0200;
    mem_rdata = 32'hA5A5_0001;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (ifu_req_ready && lsu_req_ready) both_cnt++;
      if (ifu_req_ready) begin seq[ng] = 1'b0; ng++; end
      else if (lsu_req_ready) begin seq[ng] = 1'b1; ng++; end
      if (ifu_resp_valid) ifu_cnt++;
      if (lsu_resp_valid) lsu_cnt++;
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ifu_resp_valid) ifu_cnt++;
      if (lsu_resp_valid) lsu_cnt++;
      tick();
    end
    checks++; if (ng !== 4) begin fails++; $display("FAIL rr_grant_count got=%0d exp=4", ng); end
    checks++; if (seq !== 4'b1010) begin fails++; $display("FAIL rr_order got=%b exp=1010 (bit0 first, 0=IFU)", seq); end
    checks++; if (both_cnt !== 0) begin fails++; $display("FAIL rr_both_ready got=%0d exp=0", both_cnt); end
    checks++; if ({ifu_cnt, lsu_cnt} !== {32'd2, 32'd2}) begin fails++; $display("FAIL rr_resp_counts got=%0d/%0d exp=2/2", ifu_cnt, lsu_cnt); end
    checks++; if ({ifu_rdata, lsu_rdata} !== {32'hA5A5_0001, 32'hA5A5_0001}) begin fails++; $display("FAIL rr_rdata got=%h exp=a5a50001a5a50001", {ifu_rdata, lsu_rdata}); end
  endtask

  task automatic test_latency3;
    reset_dut();
    lsu_req_valid = 1'b1; lsu_wr = 1'b0; lsu_addr = 32'h8000_0010;
    mem_rdata = 32'hBAD0_0000;
    #1;
    checks++; if (lsu_req_ready_l3 !== 1'b1) begin fails++; $display("FAIL l3_ready got=%b exp=1", lsu_req_ready_l3); end
    tick();  // A+1
    lsu_req_valid = 1'b0; mem_rdata = 32'hBAD0_0001;
    #1;
    checks++; if ({mem_rd_l3, mem_addr_l3} !== {1'b1, 32'h8000_0010}) begin fails++; $display("FAIL l3_issue got=%h exp=180000010", {mem_rd_l3, mem_addr_l3}); end
    tick();  // A+2
    mem_rdata = 32'hBAD0_0002;
    tick();  // A+3
    mem_rdata = 32'hBAD0_0003;
    #1;
    checks++; if ({lsu_resp_valid_l3, lsu_rdata_l3} !== 33'h0) begin fails++; $display("FAIL l3_early got=%h exp=0", {lsu_resp_valid_l3, lsu_rdata_l3}); end
    tick();  // A+4
    mem_rdata = 32'h1234_5678;
    tick();  // A+5
    mem_rdata = 32'hBAD0_0005;
    #1;
    checks++; if (lsu_resp_valid_l3 !== 1'b1) begin fails++; $display("FAIL l3_resp got=%b exp=1", lsu_resp_valid_l3); end
    checks++; if (lsu_rdata_l3 !== 32'h1234_5678) begin fails++; $display("FAIL l3_rdata got=%h exp=12345678", lsu_rdata_l3); end
    checks++; if ({ifu_resp_valid_l3, ifu_rdata_l3} !== 33'h0) begin fails++; $display("FAIL l3_ifu_quiet got=%h exp=0", {ifu_resp_valid_l3, ifu_rdata_l3}); end
    tick();  // A+6
    #1;
    checks++; if (busy_l3 !== 1'b0) begin fails++; $display("FAIL l3_idle got=%b exp=0", busy_l3); end
  endtask

  task automatic test_reset_in_wait;
    int resp_cnt;
    resp_cnt = 0;
    reset_dut();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040; mem_rdata = 32'h0BAD_F00D;
    tick();  // A+1 issue
    ifu_req_valid = 1'b0;
    tick();  // A+2 wait
    #1;
    checks++; if (busy_l3 !== 1'b1) begin fails++; $display("FAIL rw_busy got=%b exp=1", busy_l3); end
    rst = 1'b1;
    tick();  // A+3
    rst = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if ({busy_l3, ifu_resp_valid_l3, mem_rd_l3, ifu_req_ready_l3, lsu_req_ready_l3} !== 5'b0) begin fails++; $display("FAIL rw_ctrl got=%b exp=00000", {busy_l3, ifu_resp_valid_l3, mem_rd_l3, ifu_req_ready_l3, lsu_req_ready_l3}); end
    checks++; if ({ifu_rdata_l3, mem_addr_l3} !== 64'h0) begin fails++; $display("FAIL rw_data got=%h exp=0", {ifu_rdata_l3, mem_addr_l3}); end
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080;
    #1;
    checks++; if (ifu_req_ready_l3 !== 1'b1) begin fails++; $display("FAIL rw_fresh_ready got=%b exp=1", ifu_req_ready_l3); end
    tick();  // A+4 issue of fresh request
    ifu_req_valid = 1'b0;
    #1;
    checks++; if ({mem_rd_l3, mem_addr_l3} !== {1'b1, 32'h8000_0080}) begin fails++; $display("FAIL rw_fresh_issue got=%h exp=180000080", {mem_rd_l3, mem_addr_l3}); end
    for (int k = 0; k < 4; k++) begin
      mem_rdata = (k == 3) ? 32'hCAFE_0001 : 32'h0BAD_F00D;
      #1;
      if (ifu_resp_valid_l3) resp_cnt++;
      tick();
    end
    #1;  // A+8
    checks++; if (resp_cnt !== 0) begin fails++; $display("FAIL rw_stale_resp got=%0d exp=0", resp_cnt); end
    checks++; if ({ifu_resp_valid_l3, ifu_rdata_l3} !== {1'b1, 32'hCAFE_0001}) begin fails++; $display("FAIL rw_fresh_resp got=%h exp=1cafe0001", {ifu_resp_valid_l3, ifu_rdata_l3}); end
  endtask

  task automatic test_lsu_drop;
    int rd_cnt, ifu_cnt, lsu_cnt;
    rd_cnt = 0; ifu_cnt = 0; lsu_cnt = 0;
    reset_dut();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
    lsu_req_valid = 1'b1; lsu_wr = 1'b0; lsu_addr = 32'h8000_0400;
    mem_rdata = 32'h1111_2222;
    #1;
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin fails++; $display("FAIL drop_ready got=%b exp=10", {ifu_req_ready, lsu_req_ready}); end
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (mem_rd) rd_cnt++;
      if (ifu_resp_valid) ifu_cnt++;
      if (lsu_resp_valid) lsu_cnt++;
      tick();
    end
    checks++; if (rd_cnt !== 1) begin fails++; $display("FAIL drop_rd_pulses got=%0d exp=1", rd_cnt); end
    checks++; if ({ifu_cnt, lsu_cnt} !== {32'd1, 32'd0}) begin fails++; $display("FAIL drop_resp got=%0d/%0d exp=1/0", ifu_cnt, lsu_cnt); end
    checks++; if ({ifu_rdata, lsu_rdata} !== {32'h1111_2222, 32'h0}) begin fails++; $display("FAIL drop_rdata got=%h exp=1111222200000000", {ifu_rdata, lsu_rdata}); end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_ifu_read();
    test_lsu_store();
    test_store_zero_mask();
    test_round_robin();
    test_latency3();
    test_reset_in_wait();
    test_lsu_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
